// File: rtl/spi_msg_loader.sv
// spi_msg_loader: packs 32 SPI words into a 512-bit block for the hash core.
// Define LOADER_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module spi_msg_loader #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ss,
    input  logic         i_done,
    input  logic [15:0]  i_data,
    input  logic         i_block_ack,
    output logic [511:0] o_block,
    output logic         o_block_valid,
    output logic [15:0]  o_tx_data,
    output logic         o_overflow,
    output logic         o_frame_err
);
    typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, FULL = 2'b10} state_t;
    state_t state, state_n;
    logic [4:0] word_cnt, cnt_n;
    logic done_d, done_edge, wr, err_n, ovf_n, tflag_n, abort;
    assign done_edge = i_done & ~done_d;
    assign o_block_valid = state == FULL;
`ifdef LOADER_TIMEOUT_EN
    localparam int TW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tcnt;
    logic ss_d, tflag;
    assign abort = state == FILL && word_cnt != 5'd0 && !done_edge && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign tflag_n = abort | (tflag & ~(ss_d & ~i_ss));
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tcnt  <= '0;
            ss_d  <= 1'b1;
            tflag <= 1'b0;
        end else begin
            tcnt  <= (state == FILL && word_cnt != 5'd0 && !done_edge && !abort) ? tcnt + 1'b1 : '0;
            ss_d  <= i_ss;
            tflag <= tflag_n;
        end
    end
`else
    assign abort   = 1'b0;
    assign tflag_n = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif
    always_comb begin
        state_n = state;
        cnt_n   = word_cnt;
        wr      = 1'b0;
        err_n   = 1'b0;
        ovf_n   = o_overflow;
        case (state)
            IDLE: if (!i_ss) begin
                state_n = FILL;
                cnt_n   = 5'd0;
            end
            FILL: begin
                if (done_edge) begin
                    wr    = 1'b1;
                    cnt_n = word_cnt + 5'd1;
                end
                // a word landing with the i_ss rise is taken before the frame is judged
                if (done_edge && word_cnt == 5'd31) begin
                    state_n = FULL;
                    cnt_n   = word_cnt;
                end else if (i_ss || abort) begin
                    state_n = IDLE;
                    err_n   = cnt_n != 5'd0;
                    cnt_n   = 5'd0;
                end
            end
            FULL: if (i_block_ack) begin
                state_n = i_ss ? IDLE : FILL;
                cnt_n   = 5'd0;
                ovf_n   = 1'b0;
            end else if (done_edge) ovf_n = 1'b1;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            word_cnt    <= 5'd0;
            done_d      <= 1'b1;
            o_block     <= '0;
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
            o_tx_data   <= 16'h0000;
        end else begin
            state       <= state_n;
            word_cnt    <= cnt_n;
            done_d      <= i_done;
            o_overflow  <= ovf_n;
            o_frame_err <= err_n;
            o_tx_data   <= {state_n, ovf_n, tflag_n, 7'b0, cnt_n};
            if (wr) o_block[{~word_cnt, 4'b0} +: 16] <= i_data;
        end
    end
endmodule

// File: tb/tb_spi_msg_loader.sv
// tb_spi_msg_loader: scoreboard bench for spi_msg_loader; timeout case runs when LOADER_TIMEOUT_EN is defined.
module tb_spi_msg_loader;
    logic clk = 1'b0, rst = 1'b1, ss = 1'b1, done = 1'b0, ack = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [511:0] block;
    logic valid, overflow, frame_err;
    logic [15:0] tx;
    logic [15:0] sb[$];
    int passed = 0, total = 0;
    always #5 clk = ~clk;
    spi_msg_loader #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_ss(ss), .i_done(done), .i_data(data),
        .i_block_ack(ack), .o_block(block), .o_block_valid(valid),
        .o_tx_data(tx), .o_overflow(overflow), .o_frame_err(frame_err)
    );
    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask
    task automatic send(input logic [15:0] d, input bit push);
        @(negedge clk);
        data = d;
        done = 1'b1;
        if (push) sb.push_back(d);
        @(negedge clk);
        done = 1'b0;
    endtask
    task automatic drain();
        for (int k = 0; k < 32; k++) begin
            if (sb.size() == 0) check("sb_empty", 0, 1);
            else check("slot", block[511-16*k -: 16], sb.pop_front());
        end
    endtask
    task automatic pulse_ack(input logic ss_val);
        @(negedge clk);
        ack = 1'b1;
        ss = ss_val;
        @(negedge clk);
        ack = 1'b0;
    endtask
    initial begin
        @(negedge clk);
        check("rst_tx", tx, 16'h0000);
        check("rst_valid", valid, 0);
        check("rst_block", block, 0);
        rst = 1'b0;
        ss = 1'b0;
        @(negedge clk);
        // full block, ack three cycles after valid
        for (int i = 0; i < 31; i++) send(16'(i), 1);
        check("valid_early", valid, 0);
        send(16'h001F, 1);
        check("valid_lat", valid, 1);
        check("word0", block[511:496], 16'h0000);
        check("word31", block[15:0], 16'h001F);
        drain();
        repeat (2) @(negedge clk);
        check("valid_hold", valid, 1);
        pulse_ack(1'b0);
        check("valid_drop", valid, 0);
        check("tx_refill", tx, 16'h4000);
        // overflow while pending
        for (int i = 0; i < 32; i++) send(16'h0100 + 16'(i), 1);
        send(16'hBEEF, 0);
        check("ovf_set", overflow, 1);
        check("ovf_tx", tx, 16'hA01F);
        drain();
        pulse_ack(1'b1);
        check("ovf_clr", overflow, 0);
        check("idle_tx", tx, 16'h0000);
        send(16'h1234, 0);
        check("idle_ignore", tx, 16'h0000);
        // partial frame abort
        ss = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) send(16'h0200 + 16'(i), 0);
        check("tx_cnt5", tx, 16'h4005);
        pulse_ack(1'b0);
        check("ack_ignore", tx, 16'h4005);
        ss = 1'b1;
        @(negedge clk);
        check("ferr_pulse", frame_err, 1);
        check("ferr_tx", tx, 16'h0000);
        @(negedge clk);
        check("ferr_one", frame_err, 0);
        ss = 1'b0;
        @(negedge clk);
        ss = 1'b1;
        @(negedge clk);
        check("silent_exit", frame_err, 0);
        check("silent_tx", tx, 16'h0000);
        // last word coinciding with i_ss rise
        ss = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 31; i++) send(16'hC000 + 16'(i), 1);
        @(negedge clk);
        data = 16'hC01F;
        done = 1'b1;
        ss = 1'b1;
        sb.push_back(16'hC01F);
        @(negedge clk);
        done = 1'b0;
        check("coin_valid", valid, 1);
        check("coin_noerr", frame_err, 0);
        drain();
        pulse_ack(1'b1);
        check("coin_idle", tx, 16'h0000);
        // reset mid-fill with i_done held through release
        ss = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) send(16'hD000 + 16'(i), 0);
        check("tx_cnt10", tx, 16'h400A);
        @(negedge clk);
        rst = 1'b1;
        done = 1'b1;
        #1;
        check("arst_tx", tx, 16'h0000);
        check("arst_block", block, 0);
        check("arst_valid", valid, 0);
        check("arst_ferr", frame_err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("held_done", tx, 16'h4000);
        check("held_ferr", frame_err, 0);
        done = 1'b0;
`ifdef LOADER_TIMEOUT_EN
        begin
            int n;
            for (int i = 0; i < 3; i++) send(16'hE000 + 16'(i), 0);
            n = 0;
            while (!frame_err && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("to_ferr", frame_err, 1);
            check("to_cycles", n, 16);
            check("to_flag", tx[12], 1);
            ss = 1'b1;
            @(negedge clk);
            ss = 1'b0;
            @(negedge clk);
            check("to_clear", tx[12], 0);
        end
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
